// File: rtl/core_dmem_responder_pkg.sv
// Shared widths, base address, FSM encoding and range helper for the data-memory responder.
// Word-aligned, byte-masked, with a fixed number of wait cycles before each response.
package core_dmem_responder_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_XBYTES = CORE_XLEN / 8;
  localparam logic [CORE_XLEN-1:0] CORE_DMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // One extra bit keeps base + size from wrapping at the top of the address space.
  function automatic logic addr_in_range(input logic [CORE_XLEN-1:0] addr,
                                         input logic [CORE_XLEN-1:0] base,
                                         input int                   aw);
    logic [CORE_XLEN:0] w_lo;
    logic [CORE_XLEN:0] w_hi;
    logic [CORE_XLEN:0] w_a;
    w_a  = {1'b0, addr};
    w_lo = {1'b0, base};
    w_hi = w_lo + ((CORE_XLEN+1)'(4) << aw);
    return (w_a >= w_lo) && (w_a < w_hi);
  endfunction

endpackage

// File: rtl/core_dmem_responder_sram.sv
// Word array with per-byte write enables and synchronous write.
// The read port is combinational here; the parent registers it into its response register.
module core_dmem_sram
  import core_dmem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_widx,
  input  logic [CORE_XLEN-1:0]   i_wdata,
  input  logic [CORE_XBYTES-1:0] i_wmask,
  input  logic [AW-1:0]          i_ridx,
  output logic [CORE_XLEN-1:0]   o_rdata
);

  logic [CORE_XLEN-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < CORE_XBYTES; b++) begin
        if (i_wmask[b]) r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/core_dmem_responder.sv
// LSU-facing memory responder: one outstanding access, stores commit on accept,
// load data is captured on the edge that enters RESP and held until the response is taken.
module core_dmem_responder
  import core_dmem_responder_pkg::*;
#(
  parameter int                   AW        = 10,
  parameter logic [CORE_XLEN-1:0] BASE_ADDR = CORE_DMEM_BASE,
  parameter int                   LATENCY   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [CORE_XLEN-1:0]   req_addr,
  input  logic [CORE_XLEN-1:0]   req_wdata,
  input  logic [CORE_XBYTES-1:0] req_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CORE_XLEN-1:0]   rsp_rdata,
  output logic                   rsp_err
);

  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e          r_state;
  logic [3:0]           r_cnt;
  logic                 r_write;
  logic                 r_inr;
  logic [AW-1:0]        r_idx;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [CORE_XLEN-1:0] r_rsp_rdata;
  logic                 r_rsp_err;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_req_inr;
  logic [AW-1:0]        w_req_idx;
  logic [AW-1:0]        w_rd_idx;
  logic [CORE_XLEN-1:0] w_rd_word;
  logic                 w_rsp_load;
  logic                 w_rsp_err;
  logic [CORE_XLEN-1:0] w_rsp_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & req_valid;
  assign w_req_inr = addr_in_range(req_addr, BASE_ADDR, AW);
  assign w_req_idx = req_addr[AW+1:2];

  // With zero latency RESP is entered on the accept edge, so the live request drives the read.
  assign w_rd_idx   = w_idle ? w_req_idx : r_idx;
  assign w_rsp_load = w_idle ? (w_req_inr & ~req_write) : (r_inr & ~r_write);
  assign w_rsp_err  = w_idle ? ~w_req_inr : ~r_inr;
  assign w_rsp_data = w_rsp_load ? w_rd_word : '0;

  core_dmem_sram #(.AW(AW)) u_sram (
    .clk     (clk),
    .i_we    (w_accept & req_write & w_req_inr),
    .i_widx  (w_req_idx),
    .i_wdata (req_wdata),
    .i_wmask (req_wmask),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_inr       <= 1'b0;
      r_idx       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_inr       <= w_req_inr;
            r_idx       <= w_req_idx;
            r_req_ready <= 1'b0;
            if (LATENCY > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT_LOAD;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_err   <= w_rsp_err;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
